// File: rtl/l1_dcache_assoc.sv
// Set-associative write-back, write-allocate L1 data cache with round-robin replacement.
// Optional hit/miss counters are built when DCACHE_PERF_CNT_EN is defined.
module l1_dcache_assoc #(
    parameter int WAYS      = 2,
    parameter int SETS      = 16,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          addr,
    input  logic                 cs,
    input  logic                 we,
    input  logic [31:0]          data_i,
    output logic [31:0]          data_o,
    output logic                 stall,
    input  logic [LINE_BITS-1:0] ext_mem_data_i,
    input  logic                 ext_mem_ack,
    output logic [LINE_BITS-1:0] ext_mem_data_o,
    output logic [31:0]          ext_mem_addr,
    output logic                 ext_mem_cs,
`ifdef DCACHE_PERF_CNT_EN
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt,
`endif
    output logic                 ext_mem_we
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 27 - IDX_W;
    localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t state_reg, state_next;

    logic [TAG_W-1:0]     tag_mem  [WAYS][SETS];
    logic [LINE_BITS-1:0] data_mem [WAYS][SETS];
    logic [WAYS-1:0]      valid_reg [SETS];
    logic [WAYS-1:0]      dirty_reg [SETS];
    logic [PTR_W-1:0]     ptr_reg   [SETS];
    logic [PTR_W-1:0]     victim_reg, victim_next, hit_way;

    logic [IDX_W-1:0]     index;
    logic [TAG_W-1:0]     tag;
    logic [2:0]           word_sel;
    logic [WAYS-1:0]      way_hit;
    logic                 hit;
    logic                 victim_dirty;
    logic [LINE_BITS-1:0] hit_line;
    logic                 store_hit;
    logic                 fill;

    assign index    = addr[5+IDX_W-1:5];
    assign tag      = addr[31:5+IDX_W];
    assign word_sel = addr[4:2];

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way_cmp
        assign way_hit[gi] = valid_reg[index][gi] && (tag_mem[gi][index] == tag);
    end

    assign hit       = |way_hit;
    assign hit_line  = data_mem[hit_way][index];
    assign store_hit = (state_reg == IDLE) && cs && we && hit;
    assign fill      = (state_reg == ALLOCATE) && ext_mem_ack;

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) hit_way = PTR_W'(w);
        end
    end

    // Prefer the lowest invalid way; only fall back to round-robin when the set is full.
    always_comb begin
        logic found;
        found       = 1'b0;
        victim_next = ptr_reg[index];
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_reg[index][w]) begin
                victim_next = PTR_W'(w);
                found       = 1'b1;
            end
        end
    end

    assign victim_dirty = valid_reg[index][victim_next] && dirty_reg[index][victim_next];

    always_comb begin
        state_next     = state_reg;
        stall          = 1'b0;
        data_o         = '0;
        ext_mem_cs     = 1'b0;
        ext_mem_we     = 1'b0;
        ext_mem_addr   = '0;
        ext_mem_data_o = '0;
        case (state_reg)
            IDLE: begin
                if (cs) begin
                    if (hit) begin
                        if (!we) data_o = hit_line[{word_sel, 5'b0} +: 32];
                    end else begin
                        stall      = 1'b1;
                        state_next = victim_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                stall          = 1'b1;
                ext_mem_cs     = 1'b1;
                ext_mem_we     = 1'b1;
                ext_mem_addr   = {tag_mem[victim_reg][index], index, 5'b0};
                ext_mem_data_o = data_mem[victim_reg][index];
                if (ext_mem_ack) state_next = ALLOCATE;
            end
            ALLOCATE: begin
                stall        = 1'b1;
                ext_mem_cs   = 1'b1;
                ext_mem_addr = {addr[31:5], 5'b0};
                if (ext_mem_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            victim_reg <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s] <= '0;
                dirty_reg[s] <= '0;
                ptr_reg[s]   <= '0;
            end
        end else begin
            state_reg <= state_next;
            if ((state_reg == IDLE) && cs && !hit) victim_reg <= victim_next;
            if (store_hit) dirty_reg[index][hit_way] <= 1'b1;
            if (fill) begin
                valid_reg[index][victim_reg] <= 1'b1;
                dirty_reg[index][victim_reg] <= 1'b0;
                if ((WAYS > 1) && valid_reg[index][victim_reg])
                    ptr_reg[index] <= ptr_reg[index] + 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset so they can map onto memory primitives.
    always_ff @(posedge clk) begin
        if (store_hit) data_mem[hit_way][index][{word_sel, 5'b0} +: 32] <= data_i;
        if (fill) begin
            data_mem[victim_reg][index] <= ext_mem_data_i;
            tag_mem[victim_reg][index]  <= tag;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic replay_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            replay_reg <= 1'b0;
        end else begin
            replay_reg <= fill;
            if ((state_reg == IDLE) && cs && hit && !replay_reg) hit_cnt <= hit_cnt + 32'd1;
            if ((state_reg == IDLE) && cs && !hit) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l1_dcache_assoc.sv
// Bench for l1_dcache_assoc: directed scenarios plus random traffic against a flat-memory reference.
module tb_l1_dcache_assoc;
    localparam int WAYS = 2;
    localparam int SETS = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  addr = '0;
    logic         cs = 1'b0;
    logic         we = 1'b0;
    logic [31:0]  data_i = '0;
    logic [31:0]  data_o;
    logic         stall;
    logic [255:0] ext_mem_data_i = '0;
    logic         ext_mem_ack = 1'b0;
    logic [255:0] ext_mem_data_o;
    logic [31:0]  ext_mem_addr;
    logic         ext_mem_cs;
    logic         ext_mem_we;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    always #5 clk = ~clk;

    l1_dcache_assoc #(.WAYS(WAYS), .SETS(SETS), .LINE_BITS(256)) dut (
        .clk(clk), .rst(rst), .addr(addr), .cs(cs), .we(we), .data_i(data_i),
        .data_o(data_o), .stall(stall), .ext_mem_data_i(ext_mem_data_i),
        .ext_mem_ack(ext_mem_ack), .ext_mem_data_o(ext_mem_data_o),
        .ext_mem_addr(ext_mem_addr), .ext_mem_cs(ext_mem_cs),
`ifdef DCACHE_PERF_CNT_EN
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
        .ext_mem_we(ext_mem_we)
    );

    // Reference: backing DRAM by line, CPU-visible words, and the replacement bookkeeping.
    bit [255:0]  backing [int unsigned];
    bit [31:0]   flat    [int unsigned];
    bit          m_valid [SETS][WAYS];
    bit          m_dirty [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    int          m_ptr   [SETS];
    int          m_hits, m_misses;
    int          errors = 0;
    int          checks = 0;

    function automatic bit [255:0] backing_line(input int unsigned la);
        bit [255:0] l;
        if (!backing.exists(la)) begin
            for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
            backing[la] = l;
        end
        return backing[la];
    endfunction

    function automatic bit [31:0] view_word(input int unsigned a);
        bit [255:0] l;
        if (flat.exists(a)) return flat[a];
        l = backing_line(a & ~32'd31);
        return l[((a >> 2) & 7) * 32 +: 32];
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
            end
        end
        flat.delete();
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic do_access(input int unsigned a, input bit w, input bit [31:0] d, input int lat);
        int unsigned idx, tg, line, wb_addr;
        int          hitw, v, cnt, stall_cycles, exp_cycles;
        bit          exp_miss, exp_wb, wb_seen;
        bit [255:0]  wb_data;
        idx  = (a >> 5) % SETS;
        tg   = a >> 9;
        line = a & ~32'd31;
        hitw = -1;
        for (int k = 0; k < WAYS; k++)
            if (m_valid[idx][k] && m_tag[idx][k] == tg) hitw = k;
        exp_miss = (hitw < 0);
        v = m_ptr[idx];
        for (int k = WAYS - 1; k >= 0; k--)
            if (!m_valid[idx][k]) v = k;
        exp_wb  = exp_miss && m_valid[idx][v] && m_dirty[idx][v];
        wb_addr = (m_tag[idx][v] << 9) | (idx << 5);
        for (int k = 0; k < 8; k++) wb_data[k*32 +: 32] = view_word(wb_addr + 4 * k);

        @(posedge clk); #1;
        addr = a; we = w; data_i = d; cs = 1'b1;
        cnt = 0; stall_cycles = 0; wb_seen = 0;
        forever begin
            @(negedge clk);
            ext_mem_ack = 1'b0;
            if (!stall) break;
            stall_cycles++;
            if (stall_cycles > 500) begin
                check("stall_timeout", 1, 0);
                break;
            end
            if (stall_cycles == 1) begin
                check("ext_cs_miss_cycle", ext_mem_cs, 0);
            end else begin
                check("ext_cs", ext_mem_cs, 1);
                if (exp_wb && !wb_seen) begin
                    check("wb_we", ext_mem_we, 1);
                    check("wb_addr", ext_mem_addr, wb_addr);
                    check("wb_data", ext_mem_data_o, wb_data);
                end else begin
                    check("rf_we", ext_mem_we, 0);
                    check("rf_addr", ext_mem_addr, line);
                end
                if (cnt == lat) begin
                    ext_mem_ack = 1'b1;
                    if (exp_wb && !wb_seen) begin
                        wb_seen = 1;
                        backing[wb_addr] = wb_data;
                    end else begin
                        ext_mem_data_i = backing_line(line);
                    end
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
        exp_cycles = exp_miss ? (1 + (exp_wb ? lat + 1 : 0) + lat + 1) : 0;
        check("stall_cycles", stall_cycles, exp_cycles);
        if (!w) check("load_data", data_o, view_word(a));
        else flat[a] = d;
        if (exp_miss) begin
            m_misses++;
            if (m_valid[idx][v]) m_ptr[idx] = (m_ptr[idx] + 1) % WAYS;
            m_valid[idx][v] = 1;
            m_dirty[idx][v] = 0;
            m_tag[idx][v]   = tg;
            hitw = v;
        end else begin
            m_hits++;
        end
        if (w) m_dirty[idx][hitw] = 1;
        $display("access addr=%h we=%0d miss=%0d wb=%0d stall_cycles=%0d", a, w, exp_miss, exp_wb, stall_cycles);
        @(posedge clk); #1;
        cs = 1'b0; we = 1'b0;
    endtask

    initial begin
        bit [255:0] l;
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_ext_cs", ext_mem_cs, 0);
        check("rst_ext_we", ext_mem_we, 0);
        check("rst_ext_addr", ext_mem_addr, 0);
        check("rst_ext_data", ext_mem_data_o, 0);
        check("rst_data_o", data_o, 0);

        // Cold load with a known refill word, then store/load hits.
        l = backing_line(32'h100);
        l[31:0] = 32'hDEADBEEF;
        backing[32'h100] = l;
        do_access(32'h100, 0, 0, 10);
        check("cold_word0", data_o, 32'hDEADBEEF);
        do_access(32'h104, 1, 32'h12345678, 2);
        do_access(32'h104, 0, 0, 2);
        // Conflict misses in set 8: the second one evicts the dirty 0x100 line.
        do_access(32'h300, 0, 0, 3);
        do_access(32'h500, 0, 0, 4);
        check("wb_word1", backing[32'h100][63:32], 32'h12345678);
`ifdef DCACHE_PERF_CNT_EN
        check("perf_hit", hit_cnt, 2);
        check("perf_miss", miss_cnt, 3);
`endif
        // Set 8 pointer now selects way 1 (clean 0x300): no writeback expected.
        do_access(32'h700, 0, 0, 1);
        do_access(32'h100, 0, 0, 1);

        // Idle with stray acks.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            ext_mem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("idle_stall", stall, 0);
            check("idle_ext_cs", ext_mem_cs, 0);
        end
        ext_mem_ack = 1'b0;
        do_access(32'h104, 0, 0, 1);

        // Reset during ALLOCATE, then a late ack.
        @(posedge clk); #1;
        addr = 32'h900; cs = 1'b1; we = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_alloc_cs", ext_mem_cs, 1);
        check("mid_alloc_we", ext_mem_we, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cs = 1'b0;
        @(negedge clk);
        check("post_rst_ext_cs", ext_mem_cs, 0);
        check("post_rst_stall", stall, 0);
        ext_mem_ack = 1'b1;
        @(negedge clk);
        ext_mem_ack = 1'b0;
        check("late_ack_ext_cs", ext_mem_cs, 0);
        model_reset();
        do_access(32'h100, 0, 0, 2);

        // Random traffic over a few conflicting sets.
        for (int i = 0; i < 150; i++) begin
            int unsigned ra;
            ra = ($urandom_range(0, 5) << 9) | ($urandom_range(7, 9) << 5) | ($urandom_range(0, 7) << 2);
            do_access(ra, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3));
        end
`ifdef DCACHE_PERF_CNT_EN
        check("perf_hit_final", hit_cnt, m_hits);
        check("perf_miss_final", miss_cnt, m_misses);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/l1_dcache_assoc.md
# l1_dcache_assoc

Parametrised set-associative, write-back, write-allocate L1 data cache for the MEM stage of the 5-stage MIPS pipeline, successor to the fixed direct-mapped L1 cache. It serves 32-bit CPU loads and stores and holds the pipeline with `stall` on a miss. It refills and evicts whole 256-bit lines over the existing external memory handshake (`ext_mem_*`).

## Interface
Parameters:
- `WAYS`, 2: associativity; legal values 1, 2, 4.
- `SETS`, 16: sets per way; power of two, 2..256.
- `LINE_BITS`, 256: line width; fixed by the memory bus, only 256 legal.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `addr` in 32: CPU byte address; word-aligned.
- `cs` in 1: access request.
- `we` in 1: 1 = store, 0 = load; qualified by `cs`.
- `data_i` in 32: store data.
- `data_o` out 32: load data; combinational, valid when `cs & ~we & ~stall`.
- `stall` out 1: combinational; high while a request is unresolved.
- `ext_mem_data_i` in 256: refill line.
- `ext_mem_ack` in 1: one-cycle completion pulse from memory.
- `ext_mem_data_o` out 256: evicted line.
- `ext_mem_addr` out 32: line-aligned address, bits [4:0] = 0.
- `ext_mem_cs` out 1: memory request.
- `ext_mem_we` out 1: 1 = writeback, 0 = refill.

## Operation
- Address split: `addr[4:2]` word select; index `addr[4+log2(SETS):5]`; remaining upper bits form the tag.
- State per line: valid, dirty, tag, data. State per set: round-robin victim pointer of log2(WAYS) bits.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, `cs=0`:
  - `stall=0`; no state change.
- IDLE, hit (any way valid with a matching tag):
  - `stall=0`.
  - Load: `data_o` = selected word.
  - Store: the word is written at the clock edge and the line's dirty bit is set.
- IDLE, miss:
  - `stall=1`.
  - Victim: the lowest-index invalid way; if no way is invalid, the way at the set's pointer.
  - Victim valid and dirty: go to WRITEBACK. Otherwise: go to ALLOCATE.
- WRITEBACK:
  - Drive `ext_mem_cs=1`, `ext_mem_we=1`, `ext_mem_addr` = {victim tag, index, 5'b0}, `ext_mem_data_o` = victim line.
  - On `ext_mem_ack`: go to ALLOCATE.
- ALLOCATE:
  - Drive `ext_mem_cs=1`, `ext_mem_we=0`, `ext_mem_addr` = {addr[31:5], 5'b0}.
  - On `ext_mem_ack`: write the line into the victim way (valid=1, dirty=0, new tag) and advance the set pointer modulo `WAYS` only if the victim was valid.
  - Return to IDLE. The request is replayed in IDLE and hits.
- `stall` stays 1 in WRITEBACK and ALLOCATE regardless of `cs`.
- The CPU holds `addr`, `cs`, `we` and `data_i` stable while `stall=1`. A store miss therefore completes as a store hit after the refill.
- `WAYS=1` degenerates to direct-mapped; the pointer is absent or constant 0.

## Timing
- Reset (`rst` high at an edge):
  - state = IDLE.
  - All valid, dirty and pointer bits cleared. Data and tag arrays are not cleared.
  - `ext_mem_cs=0`, `ext_mem_we=0`, `ext_mem_addr=0`, `ext_mem_data_o=0`.
  - `data_o=0` and `stall=0` while `cs=0`.
- Hit latency: 0 cycles.
- Clean miss: `stall` high for the miss cycle, plus N cycles in ALLOCATE until ack, plus 0. `stall` falls in the first IDLE cycle after the ack edge.
- Dirty miss: the WRITEBACK duration is added.
- `ext_mem_cs` rises the cycle after the miss is detected. It stays high, with address and data stable, until the ack cycle inclusive. It drops in the cycle after the ack when the next state is IDLE, or switches `we` when going WRITEBACK to ALLOCATE.
- `ext_mem_ack` outside WRITEBACK or ALLOCATE is ignored.
- `rst` mid-WRITEBACK or mid-ALLOCATE: the transaction is abandoned and `ext_mem_cs=0` the next cycle. Any late ack is ignored.

## Configuration
- `DCACHE_PERF_CNT_EN`, when defined:
  - Adds outputs `hit_cnt` and `miss_cnt`, each 32 bits.
  - `hit_cnt` increments once per resolved request that hit on first lookup.
  - `miss_cnt` increments once per miss, counted on the IDLE-to-WRITEBACK/ALLOCATE transition; replays are not counted.
  - Both counters wrap at 2^32 and clear on `rst`.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

## Test plan
All scenarios use `WAYS=2`, `SETS=16`.
- Cold load:
  - Stimulus: after reset, load `0x100`; ack 10 cycles later with line word0=`0xDEADBEEF`.
  - Required: `ext_mem_cs=1`, `ext_mem_we=0`, `ext_mem_addr=0x100` throughout; `stall=0` and `data_o=0xDEADBEEF` the cycle after the ack.
- Store hit:
  - Stimulus: store `0x12345678` to `0x104`, then load `0x104`.
  - Required: no stall on either access; load returns `0x12345678`; no external traffic.
- Eviction with writeback:
  - Stimulus: load `0x300` (same set 8), then load `0x500`.
  - Required: WRITEBACK to `0x100` with word1=`0x12345678` and `ext_mem_we=1`, then ALLOCATE of `0x500`; pointer for set 8 = 1.
- Idle:
  - Stimulus: `cs=0` for 20 cycles with random `ack` pulses.
  - Required: `stall=0`, `ext_mem_cs=0`, no state change.
- Reset mid-allocate:
  - Stimulus: assert `rst` during ALLOCATE, then send an ack after reset.
  - Required: `ext_mem_cs=0` the next cycle; all lines invalid; the ack is ignored; a reload of `0x100` misses.
- `DCACHE_PERF_CNT_EN`:
  - Stimulus: run the sequence above without reset.
  - Required: `hit_cnt=2`, `miss_cnt=3`.
